// File: rtl/vga_pkg.sv
// vga_pkg: pixel/address widths, prefetch FSM states and standard frame sizes
package vga_pkg;
  localparam int PIX_W = 24;
  localparam int BYTES_PER_PIX = 4;
  localparam int ADDR_W = 30;
  localparam int PIX_640X480 = 307200;
  localparam int PIX_1280X960 = 1228800;
  localparam int PIX_1920X1080 = 2073600;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, FLUSH} state_t;
endpackage

// File: rtl/vga_pix_prefetch_if.sv
// vga_pix_prefetch_if: DDR3 burst read port, prefetcher is master, memory is slave
interface vga_pix_prefetch_if;
  import vga_pkg::*;
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_ack;
  logic rd_data_valid;
  logic [PIX_W-1:0] rd_data;
  modport master (output rd_req, rd_addr, input rd_ack, rd_data_valid, rd_data);
  modport slave (input rd_req, rd_addr, output rd_ack, rd_data_valid, rd_data);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with synchronous clear and occupancy output
module sync_fifo_fwft #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 24,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, do_wr, do_rd;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_wr = wr_en & ~full & ~clr;
  assign do_rd = rd_en & ~empty & ~clr;
  assign rd_data = mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
endmodule

// File: rtl/vga_pix_prefetch.sv
// vga_pix_prefetch: burst-prefetches frame pixels from DDR3 into a FWFT buffer; PREFETCH_STATS_EN adds underflow_cnt
module vga_pix_prefetch
  import vga_pkg::*;
#(
  parameter logic [ADDR_W-1:0] FRAME_BASE = '0,
  parameter int PIX_PER_FRAME = PIX_640X480,
  parameter int BURST_LEN = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  input  logic pix_req,
  output logic [PIX_W-1:0] rgb_out,
  output logic underflow,
`ifdef PREFETCH_STATS_EN
  output logic [15:0] underflow_cnt,
`endif
  vga_pix_prefetch_if.master rd
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BURST_LEN * BYTES_PER_PIX);
  state_t state, nxt;
  logic [1:0] vs_r;
  logic vs_rise, flush_pend, last_beat, take, empty, wr_en;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] count, reserved, free_slots;
  logic [31:0] frame_cnt;
  logic [PIX_W-1:0] head;
  assign vs_rise = vs_r[0] & ~vs_r[1];
  assign take = state == REQ && rd.rd_ack;
  assign last_beat = rd.rd_data_valid && beat_cnt == BW'(BURST_LEN - 1);
  assign reserved = state == WAIT_DATA ? CW'(BURST_LEN) - CW'(beat_cnt) : '0;
  assign free_slots = CW'(FIFO_DEPTH) - count - reserved;
  assign wr_en = state == WAIT_DATA && rd.rd_data_valid;
  assign rd.rd_req = state == REQ;
  assign rgb_out = empty ? '0 : head;
  sync_fifo_fwft #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) u_fifo (
    .clk, .rst, .clr(vs_rise), .wr_en, .wr_data(rd.rd_data),
    .rd_en(pix_req), .rd_data(head), .count, .empty
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = !vs_rise && free_slots >= CW'(BURST_LEN) && frame_cnt < PIX_PER_FRAME ? REQ : IDLE;
      REQ: nxt = !rd.rd_ack ? REQ : (vs_rise || flush_pend) ? FLUSH : WAIT_DATA;
      WAIT_DATA: nxt = last_beat ? IDLE : vs_rise ? FLUSH : WAIT_DATA;
      FLUSH: nxt = last_beat ? IDLE : FLUSH;
      default: nxt = IDLE;
    endcase
  end
  // a frame restart seen while requesting is deferred to the ack so rd_addr stays stable
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      vs_r <= '0;
      flush_pend <= 1'b0;
      beat_cnt <= '0;
      rd.rd_addr <= FRAME_BASE;
      frame_cnt <= '0;
      underflow <= 1'b0;
    end else begin
      state <= nxt;
      vs_r <= {vs_r[0], vsync};
      flush_pend <= state == REQ && !rd.rd_ack && (flush_pend || vs_rise);
      beat_cnt <= state == REQ ? '0 : beat_cnt + BW'(rd.rd_data_valid && (state == WAIT_DATA || state == FLUSH));
      if (take && !(vs_rise || flush_pend)) begin
        rd.rd_addr <= rd.rd_addr + STEP;
        frame_cnt <= frame_cnt + 32'(BURST_LEN);
      end else if (take || (vs_rise && state != REQ)) begin
        rd.rd_addr <= FRAME_BASE;
        frame_cnt <= '0;
      end
      underflow <= !vs_rise && (underflow || (pix_req && empty));
    end
`ifdef PREFETCH_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) underflow_cnt <= '0;
    else if (vs_rise) underflow_cnt <= '0;
    else if (pix_req && empty && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_vga_pix_prefetch.sv
// tb_vga_pix_prefetch: scoreboard bench for the pixel prefetcher (main instance plus a 64-pixel-frame instance)
module tb_vga_pix_prefetch;
  import vga_pkg::*;
  logic clk = 0, rst = 1, rst2 = 1, vsync = 0, vsync2 = 0, pix_req = 0;
  logic [PIX_W-1:0] rgb_out, rgb2;
  logic underflow, uf2;
`ifdef PREFETCH_STATS_EN
  logic [15:0] ucnt, ucnt2;
`endif
  int tests = 0, fails = 0, h2 = 0, b2 = 0;
  logic [ADDR_W-1:0] a2_last = '0;
  logic [PIX_W-1:0] seq = 24'hA00001;
  logic [ADDR_W-1:0] addr_q[$];
  logic [PIX_W-1:0] pix_q[$];
  vga_pix_prefetch_if m ();
  vga_pix_prefetch_if m2 ();
  always #5 clk = ~clk;
  vga_pix_prefetch dut (
    .clk, .rst, .vsync, .pix_req, .rgb_out, .underflow,
`ifdef PREFETCH_STATS_EN
    .underflow_cnt(ucnt),
`endif
    .rd(m)
  );
  vga_pix_prefetch #(.PIX_PER_FRAME(64)) dut2 (
    .clk, .rst(rst2), .vsync(vsync2), .pix_req(1'b1), .rgb_out(rgb2), .underflow(uf2),
`ifdef PREFETCH_STATS_EN
    .underflow_cnt(ucnt2),
`endif
    .rd(m2)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic serve(input logic [ADDR_W-1:0] a, input int beats, input int keep, input int vs_at);
    int t = 0;
    while (!m.rd_req && t < 100) begin
      tick();
      t++;
    end
    check("rd_req_seen", 32'(m.rd_req), 1);
    addr_q.push_back(a);
    m.rd_ack = 1;
    tick();
    m.rd_ack = 0;
    for (int i = 0; i < beats; i++) begin
      m.rd_data_valid = 1;
      m.rd_data = seq;
      if (i < keep) pix_q.push_back(seq);
      if (i == vs_at) vsync = 1;
      seq++;
      tick();
    end
    m.rd_data_valid = 0;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (m.rd_req && m.rd_ack)
        check("hs_addr", 32'(m.rd_addr), addr_q.size() != 0 ? 32'(addr_q.pop_front()) : 32'hFFFF_FFFF);
      if (pix_req)
        check("rgb_out", 32'(rgb_out), pix_q.size() != 0 ? 32'(pix_q.pop_front()) : 32'h0);
    end
  always @(negedge clk)
    if (!rst2 && m2.rd_req && m2.rd_ack) begin
      h2++;
      a2_last = m2.rd_addr;
      b2 = 16;
    end
  initial begin
    m2.rd_ack = 1;
    m2.rd_data_valid = 0;
    m2.rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      m2.rd_data_valid = b2 > 0;
      m2.rd_data = 24'(b2);
      if (b2 > 0) b2--;
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int hi;
    m.rd_ack = 0;
    m.rd_data_valid = 0;
    m.rd_data = '0;
    repeat (3) tick();
    check("rst_rd_req", 32'(m.rd_req), 0);
    check("rst_rd_addr", 32'(m.rd_addr), 0);
    check("rst_rgb", 32'(rgb_out), 0);
    check("rst_underflow", 32'(underflow), 0);
    rst = 0;
    rst2 = 0;
    serve(30'h000, 16, 16, -1);
    serve(30'h040, 16, 16, -1);
    serve(30'h080, 16, 16, -1);
    serve(30'h0C0, 16, 16, -1);
    hi = 0;
    repeat (10) begin
      hi += int'(m.rd_req);
      tick();
    end
    check("full_no_req", 32'(hi), 0);
    check("no_underflow", 32'(underflow), 0);
    hi = 0;
    repeat (16) begin
      pix_req = 1;
      hi += int'(m.rd_req);
      tick();
    end
    pix_req = 0;
    check("no_req_during_pops", 32'(hi), 0);
    tick();
    check("req_after_16_pops", 32'(m.rd_req), 1);
    check("addr_after_16_pops", 32'(m.rd_addr), 32'h100);
    serve(30'h100, 16, 16, -1);
    repeat (16) begin
      pix_req = 1;
      tick();
    end
    pix_req = 0;
    serve(30'h140, 16, 0, 5);
    pix_q.delete();
    vsync = 0;
    tick();
    check("req_after_flush", 32'(m.rd_req), 1);
    check("addr_after_flush", 32'(m.rd_addr), 0);
    repeat (3) begin
      pix_req = 1;
      tick();
    end
    pix_req = 0;
    check("underflow_set", 32'(underflow), 1);
`ifdef PREFETCH_STATS_EN
    check("underflow_cnt_3", 32'(ucnt), 3);
`endif
    hi = 0;
    vsync = 1;
    repeat (7) begin
      if (!m.rd_req || m.rd_addr != 0) hi++;
      tick();
    end
    check("req_held_7", 32'(hi), 0);
    check("underflow_clr", 32'(underflow), 0);
`ifdef PREFETCH_STATS_EN
    check("underflow_cnt_clr", 32'(ucnt), 0);
`endif
    vsync = 0;
    serve(30'h000, 16, 0, -1);
    tick();
    check("addr_after_req_flush", 32'(m.rd_addr), 0);
    pix_req = 1;
    tick();
    pix_req = 0;
    check("underflow_again", 32'(underflow), 1);
    serve(30'h000, 3, 0, -1);
    check("rgb_mid_burst", 32'(rgb_out), 32'(seq - 24'd3));
    rst = 1;
    #1;
    pix_q.delete();
    check("rst2_rd_req", 32'(m.rd_req), 0);
    check("rst2_rd_addr", 32'(m.rd_addr), 0);
    check("rst2_rgb", 32'(rgb_out), 0);
    check("rst2_underflow", 32'(underflow), 0);
`ifdef PREFETCH_STATS_EN
    check("rst2_underflow_cnt", 32'(ucnt), 0);
`endif
    tick();
    rst = 0;
    serve(30'h000, 16, 16, -1);
    repeat (16) begin
      pix_req = 1;
      tick();
    end
    pix_req = 0;
    check("f64_bursts", 32'(h2), 4);
    check("f64_last_addr", 32'(a2_last), 32'h0C0);
    check("f64_idle", 32'(m2.rd_req), 0);
    vsync2 = 1;
    repeat (3) tick();
    check("f64_addr_base", 32'(m2.rd_addr), 0);
    hi = 0;
    while (h2 < 5 && hi < 40) begin
      tick();
      hi++;
    end
    check("f64_resume", 32'(h2), 5);
    check("f64_resume_addr", 32'(a2_last), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
